psum_collector: RTL
===================

// Module: psum_collector
// PURPOSE
//   Downstream stage of the PE array. Captures per-column partial-sum outputs
//   (psum_vld/psum, one lane per array column) and reassembles them into a
//   row-major output feature map. Writes go to a single-port output buffer, one
//   word per cycle. Each lane has a small FIFO to absorb simultaneous column
//   valids, and a round-robin arbiter drains the FIFOs.
// PARAMETERS
//   G_ARRAY_WIDTH  6   number of PE columns = psum lanes = output row stride
//   G_DATA_WIDTH   16  psum word width (two's complement, TOP+BOT fixed point)
//   G_OUT_HEIGHT   24  output feature map rows
//   G_OUT_WIDTH    24  output feature map columns
//   G_FIFO_DEPTH   4   entries per lane FIFO (power of 2, >=2)
//   G_ADDR_WIDTH   10  output buffer address width (>= clog2(H*W))
// PORTS
//   clk_i        in   1                   clock, rising edge
//   rst_ni       in   1                   asynchronous reset, active-low
//   start_i      in   1                   1-cycle pulse: clear counters/FIFOs, arm for new map
//   psum_vld_i   in   [0:W-1]             per-lane psum valid (no backpressure)
//   psum_i       in   [0:W-1][DW-1:0]     per-lane psum data
//   wr_en_o      out  1                   output buffer write strobe
//   wr_addr_o    out  G_ADDR_WIDTH        write address = row*G_OUT_WIDTH + col
//   wr_data_o    out  G_DATA_WIDTH        write data
//   busy_o       out  1                   armed and not yet done
//   done_o       out  1                   sticky: all H*W pixels written
//   overflow_o   out  1                   sticky: a psum was dropped (lane FIFO full)
// BEHAVIOUR
//   Reset: all outputs 0, all FIFOs empty, all counters 0, state IDLE.
//   FSM: IDLE --start_i--> RUN. RUN --last write issued--> DONE.
//     DONE --start_i--> RUN. start_i in any state:
//     - flushes the FIFOs and zeroes the counters;
//     - clears done_o and overflow_o;
//     - same-cycle psum_vld_i is ignored.
//   busy_o = (state==RUN). psum_vld_i is ignored outside RUN.
//   Lane c keeps its own col_cnt (0..W_out-1) and row_cnt.
//     - Each accepted valid: pixel row = c + row_cnt*G_ARRAY_WIDTH, col = col_cnt.
//     - Then col_cnt++. When col_cnt reaches G_OUT_WIDTH-1 it wraps to 0 and row_cnt++.
//   Address is computed at enqueue. The FIFO stores {addr, data}.
//   If row >= G_OUT_HEIGHT, the entry is discarded: counters still advance,
//     nothing is enqueued, and overflow_o is not set.
//   FIFO push to a full FIFO drops the word and sets overflow_o. Counters still
//     advance, so later addresses stay correct.
//   Simultaneous push+pop on a full FIFO is legal and is not an overflow.
//   Arbiter: round-robin over non-empty lanes. Priority pointer = last granted lane + 1 (mod W).
//     One pop per cycle.
//   Outputs wr_en_o, wr_addr_o and wr_data_o are registered.
//     - Latency: psum sampled at edge k -> wr_en_o high after edge k+2 (lane idle, no contention).
//     - wr_addr_o and wr_data_o hold their last value when wr_en_o=0.
//   Write counter increments on each wr_en_o.
//     - When it reaches G_OUT_HEIGHT*G_OUT_WIDTH, done_o is set on the cycle after the last write.
//     - From then on, state is DONE.
//   Lane FIFO pointers and the write counter wrap naturally. The counter is sized for H*W.
// CONFIGURATION
//   PSUM_COLLECT_RELU_EN defined:
//     - wr_data_o = 0 when the psum MSB is 1 (negative); otherwise pass-through.
//     - Applied at the output register; addressing is unchanged.
//   Not defined: wr_data_o = psum bit-exact.
// TESTING
//   1. Reset mid-RUN with FIFOs non-empty
//      -> all outputs 0 the same cycle; after release, no writes until start_i.
//   2. Single lane 0, 24 valids, data=col
//      -> 24 writes, addr 0..23, data 0..23, first wr_en_o 2 cycles after first valid.
//   3. All 6 lanes valid on the same cycle with data=100+c
//      -> 6 consecutive writes in lane order 0..5 at addr c*24; no overflow.
//   4. Full 24x24 map: lane c gets pixels (c+6k, j) with data = row*24+col
//      -> 576 writes, each addr==data, done_o set after the 576th write, busy_o falls.
//   5. Lane 2 gets 6 back-to-back valids while other lanes hold the arbiter busy
//      -> overflow_o=1; later lane-2 addresses remain correct.
//   6. RELU_EN built, psum=16'hFFF0 -> wr_data_o=0; psum=16'h0010 -> 16'h0010.
//      Without RELU_EN -> 16'hFFF0.

Source files
------------

// File: rtl/psum_collector.sv
// Collects per-column psums into per-lane FIFOs and drains them round-robin into a row-major
// output buffer. Define PSUM_COLLECT_RELU_EN to zero negative words at the output register.
module psum_collector #(
  parameter int unsigned G_ARRAY_WIDTH = 6,
  parameter int unsigned G_DATA_WIDTH  = 16,
  parameter int unsigned G_OUT_HEIGHT  = 24,
  parameter int unsigned G_OUT_WIDTH   = 24,
  parameter int unsigned G_FIFO_DEPTH  = 4,
  parameter int unsigned G_ADDR_WIDTH  = 10
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   start_i,
  input  logic [G_ARRAY_WIDTH-1:0]               psum_vld_i,
  input  logic [G_ARRAY_WIDTH*G_DATA_WIDTH-1:0]  psum_i,
  output logic                                   wr_en_o,
  output logic [G_ADDR_WIDTH-1:0]                wr_addr_o,
  output logic [G_DATA_WIDTH-1:0]                wr_data_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   overflow_o
);
  localparam int unsigned LaneW = (G_ARRAY_WIDTH > 1) ? $clog2(G_ARRAY_WIDTH) : 1;
  localparam int unsigned PtrW  = $clog2(G_FIFO_DEPTH);
  localparam int unsigned ColW  = (G_OUT_WIDTH > 1) ? $clog2(G_OUT_WIDTH) : 1;
  localparam int unsigned RowW  = $clog2(G_OUT_HEIGHT + 1);
  localparam int unsigned NPix  = G_OUT_HEIGHT * G_OUT_WIDTH;
  localparam int unsigned CntW  = $clog2(NPix + 1);
  localparam int unsigned EntW  = G_ADDR_WIDTH + G_DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  state_e state, state_next;

  logic [ColW-1:0]          col_cnt [G_ARRAY_WIDTH];
  logic [RowW-1:0]          row_cnt [G_ARRAY_WIDTH];
  logic [31:0]              row     [G_ARRAY_WIDTH];
  logic [EntW-1:0]          entry   [G_ARRAY_WIDTH];
  logic [EntW-1:0]          mem     [G_ARRAY_WIDTH][G_FIFO_DEPTH];
  logic [PtrW:0]            wr_ptr  [G_ARRAY_WIDTH];
  logic [PtrW:0]            rd_ptr  [G_ARRAY_WIDTH];
  logic [G_ARRAY_WIDTH-1:0] accept, in_range, push, pop, full, empty;
  logic                     grant_vld;
  logic [LaneW-1:0]         grant, rr_ptr;
  logic                     pick_vld;
  logic [EntW-1:0]          pick;
  logic [G_DATA_WIDTH-1:0]  out_data;
  logic [CntW-1:0]          wr_cnt;
  logic                     last_write;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= StIdle;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      StIdle:  if (start_i) state_next = StRun;
      StRun:   if (!start_i && last_write) state_next = StDone;
      StDone:  if (start_i) state_next = StRun;
      default: state_next = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state == StRun);
  end

  assign last_write = busy_o && wr_en_o && (wr_cnt == CntW'(NPix - 1));

  always_comb begin
    for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
      full[c]  = (wr_ptr[c] ^ rd_ptr[c]) == {1'b1, {PtrW{1'b0}}};
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
    end
  end

  // Search starts at the lane after the last grant.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    pop       = '0;
    for (int i = 0; i < G_ARRAY_WIDTH; i++) begin
      idx = 32'(rr_ptr) + unsigned'(i);
      if (idx >= G_ARRAY_WIDTH) idx = idx - G_ARRAY_WIDTH;
      if (!grant_vld && busy_o && !start_i && !empty[LaneW'(idx)]) begin
        grant_vld = 1'b1;
        grant     = LaneW'(idx);
      end
    end
    if (grant_vld) pop[grant] = 1'b1;
  end

  always_comb begin
    for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
      row[c]      = unsigned'(c) + 32'(row_cnt[c]) * G_ARRAY_WIDTH;
      accept[c]   = busy_o && !start_i && psum_vld_i[c];
      in_range[c] = (row[c] < G_OUT_HEIGHT);
      push[c]     = accept[c] && in_range[c] && (!full[c] || pop[c]);
      entry[c]    = {G_ADDR_WIDTH'(row[c] * G_OUT_WIDTH + 32'(col_cnt[c])),
                     psum_i[c*G_DATA_WIDTH +: G_DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
        col_cnt[c] <= '0;
        row_cnt[c] <= '0;
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
      end
    end else if (start_i) begin
      for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
        col_cnt[c] <= '0;
        row_cnt[c] <= '0;
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
        // Counters advance even for dropped or out-of-map words so later addresses stay right.
        if (accept[c]) begin
          if (col_cnt[c] == ColW'(G_OUT_WIDTH - 1)) begin
            col_cnt[c] <= '0;
            if (in_range[c]) row_cnt[c] <= row_cnt[c] + 1'b1;
          end else begin
            col_cnt[c] <= col_cnt[c] + 1'b1;
          end
        end
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
      if (push[c]) mem[c][wr_ptr[c][PtrW-1:0]] <= entry[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pick_vld <= 1'b0;
      pick     <= '0;
    end else begin
      pick_vld <= grant_vld;
      if (grant_vld) pick <= mem[grant][rd_ptr[grant][PtrW-1:0]];
    end
  end

  always_comb begin
`ifdef PSUM_COLLECT_RELU_EN
    out_data = pick[G_DATA_WIDTH-1] ? '0 : pick[G_DATA_WIDTH-1:0];
`else
    out_data = pick[G_DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      wr_en_o <= pick_vld && !start_i;
      if (pick_vld && !start_i) begin
        wr_addr_o <= pick[EntW-1:G_DATA_WIDTH];
        wr_data_o <= out_data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt     <= '0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
      rr_ptr     <= '0;
    end else if (start_i) begin
      wr_cnt     <= '0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      if (busy_o && wr_en_o) wr_cnt <= wr_cnt + 1'b1;
      if (last_write) done_o <= 1'b1;
      if (|(accept & in_range & full & ~pop)) overflow_o <= 1'b1;
      if (grant_vld) rr_ptr <= (grant == LaneW'(G_ARRAY_WIDTH - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule
